lab2_serial_4_bit_add: RTL and testbench
========================================

Name: lab2_serial_4_bit_add

Overview:
- Bit-serial adder; the additive counterpart of the lab2 4-bit borrow subtractors.
- Computes S = x + y + Cin over WIDTH clock cycles, LSB first, using one full-adder cell and a carry flip-flop.
- Start/busy/done handshake; results are checked against the combinational subtractors by adding x to the two's complement of y.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..16).
- CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  augend, captured on accepted start.
- y  input  WIDTH  addend, captured on accepted start.
- Cin  input  1  carry-in, captured on accepted start.
- S  output  WIDTH  registered sum of last completed operation.
- Cout  output  1  registered carry-out of last completed operation.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, high in DONE.

Behaviour:
- Reset (async, any state): state=IDLE; S=0, Cout=0, busy=0, done=0; operand shift registers, carry FF and counter cleared.
- FSM has three states:
  - IDLE: on start=1, load xs<=x, ys<=y, c<=Cin, cnt<=0, go to RUN.
  - RUN: each edge, the sum bit s = xs[0]^ys[0]^c and the carry c <= maj(xs[0],ys[0],c). Shift xs/ys right. Shift s into an accumulator at MSB. cnt++. When cnt reaches WIDTH-1 on this edge, transfer the accumulator (with final s) to S and the final carry to Cout, then go to DONE.
  - DONE: done=1 for exactly one cycle. If start=1, accept new operands as in IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge k puts the block in RUN. Bits are processed on edges k+1..k+WIDTH. S/Cout update and done rises after edge k+WIDTH. The next start can be accepted at edge k+WIDTH+1.
- busy=1 exactly WIDTH cycles per operation.
- start while in RUN is ignored; operands are not re-sampled and the result is unaffected.
- x/y/Cin may change freely after the accepting edge.
- S/Cout change only on the edge entering DONE and hold between operations; the accumulator is never visible on S mid-operation.
- Arithmetic is unsigned modulo 2^WIDTH; Cout is the true carry out of bit WIDTH-1. Overflow is not flagged separately.
- Reset asserted mid-RUN aborts the operation: outputs return to 0 asynchronously and no done pulse occurs. After reset deasserts, the first start begins a fresh operation.
- Simultaneous rst and start: rst wins.

Decomposition:
- Package lab2_add_pkg holds:
  - the state typedef (IDLE, RUN, DONE, 2-bit encoding);
  - the default WIDTH constant.
- One sub-module, lab2_full_adder (a, b, ci -> s, co), purely combinational. It is instantiated once in the datapath; all sequencing stays in the top.

Test Plan:
- x=1100, y=0101, Cin=1, start pulse -> busy 4 cycles, then done=1, S=0010, Cout=1.
- x=0101, y=0101, Cin=1 -> S=1011, Cout=0. Then x=1001, y=1001, Cin=0 -> S=0010, Cout=1.
- Back-to-back: start held high through DONE with x=1101, y=0110, Cin=0, then x=0110, y=1101, Cin=1.
  - First result S=0011, Cout=1.
  - Second operation starts on the DONE edge with no IDLE cycle; second result S=0100, Cout=1.
- start pulsed and x/y changed during RUN of x=0101, y=1101, Cin=0 -> result unaffected (S=0010, Cout=1); exactly one done pulse.
- rst asserted 2 cycles into RUN -> S=0, Cout=0, busy=0 immediately and no done. A new start with x=1111, y=0001, Cin=0 then yields S=0000, Cout=1.
- Subtractor cross-check: for all 256 x/y pairs with Cin=1, compute x + ~y.
  - S must equal x - y (mod 16).
  - Cout must equal the inverse of the ripple-borrow subtractor's borrow-out with Bin=0.

Source files
------------

// File: rtl/lab2_add_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e        : controller state (IDLE, RUN, DONE), 2-bit encoding
//   DEFAULT_WIDTH  : default operand/sum width
package lab2_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/lab2_full_adder.sv
// One-bit full adder cell, purely combinational.
//   a, b  : input bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out (majority of a, b, ci)
module lab2_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/lab2_serial_4_bit_add.sv
// Bit-serial adder: S = x + y + Cin, one bit per clock, LSB first, using a
// single full-adder cell and a carry flip-flop.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, sampled only in IDLE or DONE
//   x, y, Cin  : operands, captured on the accepting edge
//   S, Cout    : registered result of the last completed operation
//   busy       : high in RUN (WIDTH cycles per operation)
//   done       : high for the single DONE cycle
//   dbg_state  : current controller state, for observation only
//
// Handshake: start is accepted on a rising edge while the block is in IDLE
// or DONE; it is ignored in RUN. done marks the one cycle in which a freshly
// updated S/Cout is first visible; holding start high through DONE chains
// the next operation with no idle cycle in between.
module lab2_serial_4_bit_add
    import lab2_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;

    lab2_full_adder u_fa (
        .a  (xs_q[0]),
        .b  (ys_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        s_d     = s_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    c_d     = Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                c_d   = fa_co;
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) bit has arrived at position 0.
                acc_d = {fa_s, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Publish including the final bit, bypassing acc_q so S
                    // only ever shows complete results.
                    s_d     = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lab2_serial_4_bit_add.sv
module tb_lab2_serial_4_bit_add;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  lab2_serial_4_bit_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .Cin       (cin),
    .S         (s),
    .Cout      (cout),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an accepted request yields x+y+Cin after WIDTH busy
  // cycles, followed by a single done cycle that may itself accept again.
  int         m_left;
  logic       m_done;
  logic [W:0] m_res;
  logic [W:0] m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_out  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_out  <= m_res;
        end
      end else if (start) begin
        m_res  <= {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        m_left <= W;
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    checks++;
    if (busy !== (m_left > 0) || done !== m_done || {cout, s} !== m_out) begin
      failures++;
      $display("FAIL cycle_model t=%0t busy=%b done=%b Cout=%b S=%b required busy=%b done=%b Cout=%b S=%b",
               $time, busy, done, cout, s, (m_left > 0), m_done, m_out[W], m_out[W-1:0]);
    end
  end

  // driver tasks
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(posedge clk); #2;
    start = 1'b1; x = a; y = b; cin = c;
    @(posedge clk); #2;
    start = 1'b0;
    x = W'($urandom_range(0, 15));
    y = W'($urandom_range(0, 15));
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout done never seen within 20 cycles", name);
    end
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] es, input logic ec);
    checks++;
    if (s !== es || cout !== ec) begin
      failures++;
      $display("FAIL %s S=%b Cout=%b required S=%b Cout=%b", name, s, cout, es, ec);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    int ndone;
    logic [W-1:0] exp_s;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_lit("reset_outputs", 4'b0000, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    rst = 1'b0;

    // basic operations
    start_op(4'b1100, 4'b0101, 1'b1);
    wait_done("op1");
    check_lit("op1_1100_0101_c1", 4'b0010, 1'b1);

    start_op(4'b0101, 4'b0101, 1'b1);
    wait_done("op2");
    check_lit("op2_0101_0101_c1", 4'b1011, 1'b0);

    start_op(4'b1001, 4'b1001, 1'b0);
    wait_done("op3");
    check_lit("op3_1001_1001_c0", 4'b0010, 1'b1);

    // back-to-back: start held through DONE
    @(posedge clk); #2;
    start = 1'b1; x = 4'b1101; y = 4'b0110; cin = 1'b0;
    @(posedge clk); #2;
    x = 4'b0110; y = 4'b1101; cin = 1'b1;
    wait_done("b2b_first");
    check_lit("b2b_first", 4'b0011, 1'b1);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check_bit("b2b_no_idle_busy", busy, 1'b1);
    wait_done("b2b_second");
    check_lit("b2b_second", 4'b0100, 1'b1);

    // start and operand changes during RUN are ignored
    @(posedge clk); #2;
    start = 1'b1; x = 4'b0101; y = 4'b1101; cin = 1'b0;
    @(posedge clk); #2;
    start = 1'b0; x = 4'b1111; y = 4'b1111; cin = 1'b1;
    ndone = 0;
    exp_s = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        check_lit("run_ignore_result", 4'b0010, 1'b1);
      end
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL run_ignore_done_count got=%0d required=1", ndone);
    end

    // reset mid-RUN
    start_op(4'b1010, 4'b0011, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_lit("rst_mid_run_outputs", 4'b0000, 1'b0);
    check_bit("rst_mid_run_busy", busy, 1'b0);
    check_bit("rst_mid_run_done", done, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL rst_no_done got=%0d required=0", ndone);
    end
    start_op(4'b1111, 4'b0001, 1'b0);
    wait_done("after_rst");
    check_lit("after_rst_1111_0001", 4'b0000, 1'b1);

    // subtractor cross-check: x + ~y + 1 == x - y, Cout == ~borrow
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [W-1:0] av, bv;
        av = W'(a);
        bv = W'(b);
        start_op(av, ~bv, 1'b1);
        wait_done("sub_xcheck");
        checks++;
        if (s !== W'(a - b) || cout !== (a >= b)) begin
          failures++;
          $display("FAIL sub_xcheck x=%0d y=%0d S=%b Cout=%b required S=%b Cout=%b",
                   a, b, s, cout, W'(a - b), (a >= b));
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
